can_tx_mailbox: RTL and testbench

CAN_TX_MAILBOX -- requirements
Module: can_tx_mailbox

---
 rtl/can_tx_mailbox_pkg.sv | 27 ++
 rtl/can_tx_mailbox_if.sv | 22 ++
 rtl/can_tx_frame_ram.sv | 26 ++
 rtl/can_tx_mailbox.sv | 173 +++++++++++++++++
 tb/tb_can_tx_mailbox.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/can_tx_mailbox_pkg.sv
// rtl/can_tx_mailbox_pkg.sv - shared types and constants for the CAN transmit mailbox
package can_tx_mailbox_pkg;

    localparam int CAN_MAX_BYTES = 8;
    localparam int ERR_CODE_BIT  = 2;

    typedef logic [1:0] can_tx_state_t;

    localparam can_tx_state_t ST_IDLE  = 2'd0;
    localparam can_tx_state_t ST_ARMED = 2'd1;
    localparam can_tx_state_t ST_POP   = 2'd2;
    localparam can_tx_state_t ST_RETRY = 2'd3;

    typedef struct packed {
        logic [28:0] id;
        logic        ext;
        logic        rtr;
        logic [3:0]  size;
        logic [63:0] data;
    } can_frame_t;

    // A classic CAN frame never carries more than eight data bytes.
    function automatic logic [3:0] clamp_size(input logic [3:0] size);
        return (size > 4'(CAN_MAX_BYTES)) ? 4'(CAN_MAX_BYTES) : size;
    endfunction

endpackage

// File: rtl/can_tx_mailbox_if.sv
// rtl/can_tx_mailbox_if.sv - frame-write handshake bundle for the CAN transmit mailbox
interface can_tx_mailbox_if;

    logic        wr_valid;
    logic        wr_ready;
    logic [28:0] wr_id;
    logic        wr_ext;
    logic        wr_rtr;
    logic [3:0]  wr_size;
    logic [63:0] wr_data;

    modport master (
        output wr_valid, wr_id, wr_ext, wr_rtr, wr_size, wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_id, wr_ext, wr_rtr, wr_size, wr_data,
        output wr_ready
    );

endinterface

// File: rtl/can_tx_frame_ram.sv
// rtl/can_tx_frame_ram.sv - frame storage, one write port and one asynchronous read port
module can_tx_frame_ram
    import can_tx_mailbox_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  can_frame_t               wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output can_frame_t               rdata
);

    can_frame_t mem [DEPTH];

    // Storage is never reset; the occupancy count decides what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/can_tx_mailbox.sv
// rtl/can_tx_mailbox.sv - CAN transmit mailbox queue and arbitration/retry control (option: CAN_TX_RETRY_LIMIT_EN)
module can_tx_mailbox
    import can_tx_mailbox_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 16
) (
    input  logic                   clk,
    input  logic                   RST,
    can_tx_mailbox_if.slave        wr,
    output logic                   pkt_ready,
    output logic [28:0]            msg_id,
    output logic                   EXT,
    output logic                   RTR,
    output logic [3:0]             pkt_size,
    output logic [63:0]            data,
    input  logic                   tx_done,
    input  logic                   tx_arb_loss,
    input  logic [1:0]             tx_err_code,
    input  logic                   abort,
    input  logic                   bus_off,
    output logic [$clog2(DEPTH):0] count,
    output logic                   tx_ok,
    output logic                   tx_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    can_tx_state_t state_q, state_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          tx_ok_q, tx_ok_d;
    logic          tx_drop_q, tx_drop_d;
    logic          pop;
    logic          wr_fire;
    can_frame_t    wr_frame;
    can_frame_t    ram_rdata;

    assign wr.wr_ready = (count_q < CW'(DEPTH)) && !abort;
    assign wr_fire     = wr.wr_valid && wr.wr_ready;

    assign wr_frame.id   = wr.wr_id;
    assign wr_frame.ext  = wr.wr_ext;
    assign wr_frame.rtr  = wr.wr_rtr;
    assign wr_frame.size = clamp_size(wr.wr_size);
    assign wr_frame.data = wr.wr_data;

    can_tx_frame_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr_q),
        .wdata (wr_frame),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    // Next-state logic: transmitter results, pops, writes, then abort overriding all.
    always_comb begin
        state_d   = state_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        retry_d   = retry_q;
        tx_ok_d   = 1'b0;
        tx_drop_d = 1'b0;
        pop       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((count_q != '0) && !bus_off) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus_off) begin
                    state_d = ST_IDLE;
                end else if (tx_done) begin
                    state_d = ST_POP;
                    tx_ok_d = 1'b1;
                    retry_d = '0;
                end else if (tx_err_code == 2'(ERR_CODE_BIT)) begin
                    state_d = ST_RETRY;
                    if (retry_q != {RW{1'b1}}) begin
                        retry_d = retry_q + RW'(1);
                    end
                end else if (tx_arb_loss) begin
                    // Lost arbitration: the same head simply competes again.
                    state_d = ST_ARMED;
                end
            end
            ST_POP: begin
                pop = 1'b1;
            end
            ST_RETRY: begin
`ifdef CAN_TX_RETRY_LIMIT_EN
                if (retry_q >= RW'(MAX_RETRY)) begin
                    pop       = 1'b1;
                    tx_drop_d = 1'b1;
                    retry_d   = '0;
                end else begin
                    state_d = bus_off ? ST_IDLE : ST_ARMED;
                end
`else
                state_d = bus_off ? ST_IDLE : ST_ARMED;
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(wr_fire) - CW'(pop);

        // After removing the head, re-arm only if something is left to send.
        if (pop) begin
            state_d = ((count_d != '0) && !bus_off) ? ST_ARMED : ST_IDLE;
        end

        if (abort) begin
            state_d   = ST_IDLE;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            count_d   = '0;
            retry_d   = '0;
            tx_ok_d   = 1'b0;
            tx_drop_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            retry_q   <= '0;
            tx_ok_q   <= 1'b0;
            tx_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            retry_q   <= retry_d;
            tx_ok_q   <= tx_ok_d;
            tx_drop_q <= tx_drop_d;
        end
    end

    assign pkt_ready = (state_q == ST_ARMED) && !bus_off;
    assign msg_id    = (count_q != '0) ? ram_rdata.id   : '0;
    assign EXT       = (count_q != '0) ? ram_rdata.ext  : 1'b0;
    assign RTR       = (count_q != '0) ? ram_rdata.rtr  : 1'b0;
    assign pkt_size  = (count_q != '0) ? ram_rdata.size : '0;
    assign data      = (count_q != '0) ? ram_rdata.data : '0;
    assign count     = count_q;
    assign tx_ok     = tx_ok_q;
    assign tx_drop   = tx_drop_q;

endmodule

// File: tb/tb_can_tx_mailbox.sv
// tb/tb_can_tx_mailbox.sv - self-checking bench for can_tx_mailbox against a queue-based model (option: CAN_TX_RETRY_LIMIT_EN)
module tb_can_tx_mailbox;
    import can_tx_mailbox_pkg::*;

    localparam int DEPTH = 4;
    localparam int MAXR  = 3;
    localparam int RSAT  = (1 << $clog2(MAXR + 1)) - 1;

    logic        clk = 1'b0;
    logic        RST;
    logic        pkt_ready;
    logic [28:0] msg_id;
    logic        EXT;
    logic        RTR;
    logic [3:0]  pkt_size;
    logic [63:0] data;
    logic        tx_done;
    logic        tx_arb_loss;
    logic [1:0]  tx_err_code;
    logic        abort;
    logic        bus_off;
    logic [2:0]  count;
    logic        tx_ok;
    logic        tx_drop;

    can_tx_mailbox_if wif ();

    can_tx_mailbox #(
        .DEPTH     (DEPTH),
        .MAX_RETRY (MAXR)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .wr          (wif),
        .pkt_ready   (pkt_ready),
        .msg_id      (msg_id),
        .EXT         (EXT),
        .RTR         (RTR),
        .pkt_size    (pkt_size),
        .data        (data),
        .tx_done     (tx_done),
        .tx_arb_loss (tx_arb_loss),
        .tx_err_code (tx_err_code),
        .abort       (abort),
        .bus_off     (bus_off),
        .count       (count),
        .tx_ok       (tx_ok),
        .tx_drop     (tx_drop)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_ARMED, M_POP, M_RETRY} mph_t;

    can_frame_t m_q[$];
    mph_t       m_ph    = M_IDLE;
    int         m_retry = 0;
    bit         m_ok    = 1'b0;
    bit         m_drop  = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic can_frame_t model_head();
        can_frame_t f;
        f = '0;
        if (m_q.size() > 0) f = m_q[0];
        return f;
    endfunction

    task automatic check_all();
        chk("count", 128'(count), 128'(m_q.size()));
        chk("wr_ready", 128'(wif.wr_ready), 128'((m_q.size() < DEPTH) && !abort));
        chk("pkt_ready", 128'(pkt_ready), 128'((m_ph == M_ARMED) && !bus_off));
        chk("head", 128'({msg_id, EXT, RTR, pkt_size, data}), 128'(model_head()));
        chk("tx_ok", 128'(tx_ok), 128'(m_ok));
        chk("tx_drop", 128'(tx_drop), 128'(m_drop));
    endtask

    task automatic model_step();
        bit         wf;
        bit         pop;
        mph_t       nph;
        can_frame_t f;
        wf = wif.wr_valid && (m_q.size() < DEPTH) && !abort;
        if (RST || abort) begin
            m_q.delete();
            m_ph = M_IDLE; m_retry = 0; m_ok = 0; m_drop = 0;
            return;
        end
        m_ok = 0; m_drop = 0; pop = 0; nph = m_ph;
        case (m_ph)
            M_IDLE:  if (m_q.size() > 0 && !bus_off) nph = M_ARMED;
            M_ARMED: begin
                if (bus_off) nph = M_IDLE;
                else if (tx_done) begin m_ok = 1; nph = M_POP; m_retry = 0; end
                else if (tx_err_code == 2'd2) begin
                    nph = M_RETRY;
                    m_retry = (m_retry < RSAT) ? m_retry + 1 : RSAT;
                end
            end
            M_POP:   pop = 1;
            M_RETRY: begin
`ifdef CAN_TX_RETRY_LIMIT_EN
                if (m_retry >= MAXR) begin pop = 1; m_drop = 1; m_retry = 0; end
                else nph = bus_off ? M_IDLE : M_ARMED;
`else
                nph = bus_off ? M_IDLE : M_ARMED;
`endif
            end
            default: nph = M_IDLE;
        endcase
        if (pop) void'(m_q.pop_front());
        if (wf) begin
            f.id = wif.wr_id; f.ext = wif.wr_ext; f.rtr = wif.wr_rtr;
            f.size = (wif.wr_size > 4'd8) ? 4'd8 : wif.wr_size;
            f.data = wif.wr_data;
            m_q.push_back(f);
        end
        if (pop) nph = (m_q.size() > 0 && !bus_off) ? M_ARMED : M_IDLE;
        m_ph = nph;
    endtask

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [28:0] id, input logic [3:0] sz, input logic [63:0] d);
        wif.wr_id = id; wif.wr_ext = id[0]; wif.wr_rtr = id[1];
        wif.wr_size = sz; wif.wr_data = d; wif.wr_valid = 1'b1;
        cycle();
        wif.wr_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (pkt_ready !== 1'b1 && n < 30) begin
            cycle();
            n++;
        end
        chk(name, 128'(pkt_ready), 128'(1));
    endtask

    task automatic send_ok(input logic [28:0] exp_id);
        wait_ready("wait_armed");
        chk("head_id_lit", 128'(msg_id), 128'(exp_id));
        tx_done = 1'b1;
        cycle();
        tx_done = 1'b0;
        chk("tx_ok_lit", 128'(tx_ok), 128'(1));
    endtask

    task automatic flush();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("flush_count", 128'(count), 128'(0));
    endtask

    task automatic err_pulse();
        wait_ready("wait_armed_err");
        tx_err_code = 2'd2;
        cycle();
        tx_err_code = 2'd0;
    endtask

    initial begin
        RST = 1'b1; tx_done = 0; tx_arb_loss = 0; tx_err_code = 0; abort = 0; bus_off = 0;
        wif.wr_valid = 0; wif.wr_id = '0; wif.wr_ext = 0; wif.wr_rtr = 0;
        wif.wr_size = '0; wif.wr_data = '0;
        cycle();
        cycle();
        RST = 1'b0;
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_pkt_ready", 128'(pkt_ready), 128'(0));
        chk("rst_head", 128'({msg_id, EXT, RTR, pkt_size, data}), 128'(0));

        // Three frames transmitted in order.
        put(29'h123, 4'd2, 64'h11);
        put(29'h456, 4'd3, 64'h22);
        put(29'h789, 4'd4, 64'h33);
        chk("three_count", 128'(count), 128'(3));
        chk("model_three", 128'(m_q.size()), 128'(3));
        send_ok(29'h123);
        send_ok(29'h456);
        send_ok(29'h789);
        cycle();
        chk("drain_count", 128'(count), 128'(0));
        chk("drain_idle", 128'(pkt_ready), 128'(0));

        // Full buffer, ignored fifth write, write during a pop, pointer wrap.
        for (int i = 0; i < 4; i++) put(29'h0A0 + 29'(i), 4'd8, 64'(i));
        chk("full_count", 128'(count), 128'(4));
        chk("full_wr_ready", 128'(wif.wr_ready), 128'(0));
        put(29'h5FF, 4'd1, 64'hDEAD);
        chk("full_ignored", 128'(count), 128'(4));
        send_ok(29'h0A0);
        cycle();
        wait_ready("wait_armed_wrap");
        tx_done = 1'b1;
        cycle();
        tx_done = 1'b0;
        chk("pop_state_count", 128'(count), 128'(3));
        put(29'h0A4, 4'd5, 64'h44);
        chk("pop_write_count", 128'(count), 128'(3));
        send_ok(29'h0A2);
        send_ok(29'h0A3);
        send_ok(29'h0A4);
        cycle();

        // Arbitration loss keeps the head armed; oversized length clamps to 8.
        put(29'h100, 4'd12, 64'h0102030405060708);
        wait_ready("wait_arb");
        tx_arb_loss = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("arb_pkt_ready", 128'(pkt_ready), 128'(1));
            chk("arb_head", 128'(msg_id), 128'(29'h100));
        end
        tx_arb_loss = 1'b0;
        chk("clamp_size", 128'(pkt_size), 128'(8));
        send_ok(29'h100);
        cycle();

        // tx_done wins over a simultaneous retry error.
        put(29'h200, 4'd1, 64'h1);
        wait_ready("wait_both");
        tx_done = 1'b1; tx_err_code = 2'd2;
        cycle();
        tx_done = 1'b0; tx_err_code = 2'd0;
        chk("both_ok", 128'(tx_ok), 128'(1));
        cycle();
        chk("both_popped", 128'(count), 128'(0));

        // Retry errors: dropped after the limit, or retried forever.
        put(29'h300, 4'd1, 64'h3);
        put(29'h301, 4'd1, 64'h4);
`ifdef CAN_TX_RETRY_LIMIT_EN
        for (int i = 0; i < MAXR; i++) err_pulse();
        cycle();
        chk("drop_pulse", 128'(tx_drop), 128'(1));
        chk("drop_next_head", 128'(msg_id), 128'(29'h301));
        chk("drop_count", 128'(count), 128'(1));
`else
        for (int i = 0; i < 20; i++) err_pulse();
        cycle();
        chk("nodrop_count", 128'(count), 128'(2));
        chk("nodrop_head", 128'(msg_id), 128'(29'h300));
`endif
        flush();

        // Abort with three queued while armed.
        for (int i = 0; i < 3; i++) put(29'h400 + 29'(i), 4'd2, 64'(i));
        wait_ready("wait_abort");
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        chk("abort_count", 128'(count), 128'(0));
        chk("abort_pkt_ready", 128'(pkt_ready), 128'(0));
        chk("abort_no_drop", 128'(tx_drop), 128'(0));

        // Reset while armed.
        for (int i = 0; i < 3; i++) put(29'h500 + 29'(i), 4'd2, 64'(i));
        wait_ready("wait_rst");
        RST = 1'b1;
        cycle();
        RST = 1'b0;
        chk("rst_mid_count", 128'(count), 128'(0));
        chk("rst_mid_outputs", 128'({pkt_ready, tx_ok, tx_drop, msg_id, pkt_size, data}), 128'(0));

        // Bus-off freezes the queue and drops pkt_ready, then resumes.
        put(29'h600, 4'd2, 64'h6);
        wait_ready("wait_busoff");
        bus_off = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("busoff_pkt_ready", 128'(pkt_ready), 128'(0));
        chk("busoff_count", 128'(count), 128'(1));
        bus_off = 1'b0;
        send_ok(29'h600);
        cycle();

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            wif.wr_valid = ($urandom % 2) == 0;
            wif.wr_id    = 29'($urandom);
            wif.wr_ext   = 1'($urandom);
            wif.wr_rtr   = 1'($urandom);
            wif.wr_size  = 4'($urandom);
            wif.wr_data  = {$urandom, $urandom};
            tx_done      = ($urandom % 5) == 0;
            tx_arb_loss  = ($urandom % 4) == 0;
            tx_err_code  = (($urandom % 3) == 0) ? 2'd2 : 2'($urandom);
            abort        = ($urandom % 80) == 0;
            RST          = ($urandom % 400) == 0;
            if (($urandom % 25) == 0) bus_off = ~bus_off;
            cycle();
        end
        wif.wr_valid = 0; tx_done = 0; tx_arb_loss = 0; tx_err_code = 0;
        abort = 0; RST = 0; bus_off = 0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
